mem_ctrl_arbiter: RTL and testbench
===================================

Name: mem_ctrl_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between instruction fetch (IF) and the MEM-stage load/store.
- Serialises each 1/2/4-byte access into byte cycles and assembles read data little-endian.
- Returns a one-cycle done pulse per access.
- Sits between the IF/MEM stages and the external RAM. The pipeline-register stall logic keys off the done pulses.

Parameters:
- ADDR_W, 32, width of all address ports.
- DATA_W, 32, width of instruction and load/store data.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- rdy  in  1  global enable; low freezes the block
- if_req  in  1  IF fetch request; level, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  jump/flush; aborts a fetch in progress
- if_done  out  1  one-cycle pulse; if_inst valid
- if_inst  out  DATA_W  fetched word
- mem_req  in  1  load/store request; level, held until mem_done
- mem_wr  in  1  0 = read, 1 = write
- mem_addr  in  ADDR_W  load/store address
- mem_type  in  2  00 byte, 01 half, 10/11 word
- mem_store_data  in  DATA_W  store data; low N bytes used
- mem_done  out  1  one-cycle pulse
- mem_load_data  out  DATA_W  raw load data, zero-extended; sign extension is done in MEM
- ram_addr  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  byte to RAM
- ram_din  in  8  byte from RAM; valid in the cycle after its address was driven

Behaviour:
- Reset (async): state IDLE, counter 0. All outputs 0: ram_addr, ram_wr, ram_dout, if_done, if_inst, mem_done, mem_load_data.
- rdy low: all registers hold. ram_wr is gated combinationally to 0.
- States:
  - IDLE: grant on an edge when a request is present. mem_req has priority over if_req; a granted access is never preempted.
  - IF_RD: N = 4 bytes.
  - LS_RD: N = 1, 2 or 4 bytes.
  - LS_WR: N = 1, 2 or 4 bytes.
  - DONE: one cycle; all requests are ignored; then IDLE.
- Cycle numbering: grant edge E0 → cycle C0. Byte i address (base + i) is driven in Ci, for i = 0..N-1.
- Reads:
  - Byte i is captured from ram_din at edge E(i+2) into bits [8i+7:8i]; unused upper bytes are 0.
  - Done pulse is registered and high during C(N+1); data output updates in the same cycle.
  - Latency from grant: word 5 cycles, half 3, byte 2.
- Writes:
  - ram_wr = 1 and ram_dout = mem_store_data[8i+7:8i] during Ci.
  - mem_done high during CN, with ram_wr = 0 in CN.
- The done pulse coincides with state DONE. The requester deasserts or changes its request in that cycle; the next grant is at the earliest edge after DONE.
- if_flush:
  - Sampled high at any edge while in IF_RD, including the final capture edge: go to IDLE; no if_done, if_inst unchanged.
  - In IDLE, a flushed cycle grants no IF request.
  - if_flush never affects LS states.
- Address arithmetic is modulo 2^ADDR_W. Misaligned accesses are legal and are simply byte-serial.
- Outside the asserted done cycle, if_done and mem_done are 0. if_inst and mem_load_data hold their last value.

Optional Feature:
- Macro: IO_BUFFER_FULL_EN.
- Defined:
  - Adds input io_buffer_full (1 bit).
  - A write with mem_addr[17:16] == 2'b11 (IO range, ≥ 0x30000) is not granted while io_buffer_full is high. Grant occurs at the first edge in IDLE with io_buffer_full low.
  - A pending if_req may be served while such a write waits.
  - Once granted, a write completes regardless of io_buffer_full.
- Undefined: the port is absent and IO writes are granted like any other write.

Test Plan:
- Word fetch: if_req = 1, if_addr = 0x100, RAM bytes 13,05,00,00 → if_done high exactly in C5; if_inst = 0x00000513; ram_addr sequence 0x100..0x103.
- Conflict: if_req and mem_req (write, type 10, addr 0x200, data 0xDEADBEEF) both rise together → write first. RAM gets EF,BE,AD,DE at 0x200..0x203 with ram_wr high for exactly 4 cycles; mem_done in C4. The fetch is granted after DONE.
- Half load: addr 0x11, bytes 0x80, 0xFF → mem_load_data = 0x0000FF80; mem_done in C3.
- Flush: if_flush pulsed at E3 of a fetch → no if_done, state IDLE at the next cycle; a following mem_req is granted immediately.
- rdy low for 3 cycles mid-write at byte 1, then restored → no extra write, ram_wr low while frozen; bytes land correctly; mem_done is 3 cycles late.
- Async reset mid-LS_RD (rst rising between edges) → all outputs 0 immediately; no done pulse after release.

Source files
------------

// File: rtl/mem_ctrl_arbiter_if.sv
// Bundle between the IF/MEM stages, the memory arbiter and the byte-wide RAM.
// IO_BUFFER_FULL_EN adds the io_buffer_full back-pressure input.
interface mem_ctrl_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [DATA_W-1:0] if_inst;

    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_type;
    logic [DATA_W-1:0] mem_store_data;
    logic              mem_done;
    logic [DATA_W-1:0] mem_load_data;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
`ifdef IO_BUFFER_FULL_EN
    logic              io_buffer_full;
`endif

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_wr, mem_addr, mem_type, mem_store_data,
        input  ram_din,
`ifdef IO_BUFFER_FULL_EN
        input  io_buffer_full,
`endif
        output if_done, if_inst, mem_done, mem_load_data,
        output ram_addr, ram_wr, ram_dout
    );

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_wr, mem_addr, mem_type, mem_store_data,
        output ram_din,
`ifdef IO_BUFFER_FULL_EN
        output io_buffer_full,
`endif
        input  if_done, if_inst, mem_done, mem_load_data,
        input  ram_addr, ram_wr, ram_dout
    );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
// Shares the byte-wide RAM port between instruction fetch and MEM load/store,
// serialising 1/2/4-byte accesses. IO_BUFFER_FULL_EN holds off IO-range writes.
module mem_ctrl_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    mem_ctrl_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_RD,
        S_LS_RD,
        S_LS_WR,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  size_q, size_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic              mem_done_q, mem_done_d;
    logic [DATA_W-1:0] mem_load_data_q, mem_load_data_d;

    logic              io_block_c;
    logic [CNT_W-1:0]  mem_size_c;
    logic [1:0]        cap_idx_c;
    logic [1:0]        nxt_idx_c;
    logic [DATA_W-1:0] merged_c;

`ifdef IO_BUFFER_FULL_EN
    assign io_block_c = bus.mem_wr && (bus.mem_addr[17:16] == 2'b11) && bus.io_buffer_full;
`else
    assign io_block_c = 1'b0;
`endif

    always_comb begin
        case (bus.mem_type)
            2'b00:   mem_size_c = CNT_W'(1);
            2'b01:   mem_size_c = CNT_W'(2);
            default: mem_size_c = CNT_W'(4);
        endcase
    end

    // Byte returned by RAM this cycle belongs to the address driven one cycle earlier.
    assign cap_idx_c = 2'(cnt_q - CNT_W'(1));
    assign nxt_idx_c = 2'(cnt_q + CNT_W'(1));

    always_comb begin
        merged_c = buf_q;
        merged_c[{cap_idx_c, 3'b000} +: 8] = bus.ram_din;
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        size_d          = size_q;
        buf_d           = buf_q;
        ram_addr_d      = ram_addr_q;
        ram_wr_d        = ram_wr_q;
        ram_dout_d      = ram_dout_q;
        if_done_d       = 1'b0;
        if_inst_d       = if_inst_q;
        mem_done_d      = 1'b0;
        mem_load_data_d = mem_load_data_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.mem_req && !io_block_c) begin
                    size_d     = mem_size_c;
                    ram_addr_d = bus.mem_addr;
                    if (bus.mem_wr) begin
                        buf_d      = bus.mem_store_data;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = bus.mem_store_data[7:0];
                        state_d    = S_LS_WR;
                    end else begin
                        buf_d   = '0;
                        state_d = S_LS_RD;
                    end
                end else if (bus.if_req && !bus.if_flush) begin
                    size_d     = CNT_W'(4);
                    ram_addr_d = bus.if_addr;
                    buf_d      = '0;
                    state_d    = S_IF_RD;
                end
            end

            S_IF_RD, S_LS_RD: begin
                if (state_q == S_IF_RD && bus.if_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == size_q) begin
                    state_d = S_DONE;
                    if (state_q == S_IF_RD) begin
                        if_done_d = 1'b1;
                        if_inst_d = merged_c;
                    end else begin
                        mem_done_d      = 1'b1;
                        mem_load_data_d = merged_c;
                    end
                end else begin
                    if (cnt_q != '0) begin
                        buf_d = merged_c;
                    end
                    if (cnt_q + CNT_W'(1) < size_q) begin
                        ram_addr_d = ram_addr_q + ADDR_W'(1);
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_LS_WR: begin
                if (cnt_q + CNT_W'(1) < size_q) begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    ram_dout_d = buf_q[{nxt_idx_c, 3'b000} +: 8];
                end else begin
                    ram_wr_d   = 1'b0;
                    mem_done_d = 1'b1;
                    state_d    = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            size_q          <= '0;
            buf_q           <= '0;
            ram_addr_q      <= '0;
            ram_wr_q        <= 1'b0;
            ram_dout_q      <= '0;
            if_done_q       <= 1'b0;
            if_inst_q       <= '0;
            mem_done_q      <= 1'b0;
            mem_load_data_q <= '0;
        end else if (rdy) begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            size_q          <= size_d;
            buf_q           <= buf_d;
            ram_addr_q      <= ram_addr_d;
            ram_wr_q        <= ram_wr_d;
            ram_dout_q      <= ram_dout_d;
            if_done_q       <= if_done_d;
            if_inst_q       <= if_inst_d;
            mem_done_q      <= mem_done_d;
            mem_load_data_q <= mem_load_data_d;
        end
    end

    // Write strobe is masked while frozen so a held byte is not written twice.
    assign bus.ram_wr        = ram_wr_q & rdy;
    assign bus.ram_addr      = ram_addr_q;
    assign bus.ram_dout      = ram_dout_q;
    assign bus.if_done       = if_done_q;
    assign bus.if_inst       = if_inst_q;
    assign bus.mem_done      = mem_done_q;
    assign bus.mem_load_data = mem_load_data_q;

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Randomized bench for mem_ctrl_arbiter against a byte-array reference memory.
module tb_mem_ctrl_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic ram_init = 1'b1;

    always #5 clk = ~clk;

    mem_ctrl_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_ctrl_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    logic [7:0]  ram_mem [256];
    logic [7:0]  ref_mem [256];
    logic [39:0] wlog [$];
    int n_checks = 0;
    int n_errors = 0;
    int n_if_pulses = 0;
    int n_mem_pulses = 0;

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // RAM device: one-cycle read latency, write on strobe, logs every write.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_byte(i);
        end else if (bus.ram_wr) begin
            ram_mem[bus.ram_addr[7:0]] <= bus.ram_dout;
            wlog.push_back({bus.ram_addr, bus.ram_dout});
        end
        bus.ram_din <= ram_mem[bus.ram_addr[7:0]];
    end

    always @(negedge clk) begin
        if (bus.if_done)  n_if_pulses++;
        if (bus.mem_done) n_mem_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] t);
        return (t == 2'b00) ? 1 : ((t == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = ref_mem[8'(addr + 32'(i))];
        return r;
    endfunction

    // Starts at a negedge with the arbiter idle; ends one idle negedge after done.
    task automatic do_read(input bit is_if, input logic [31:0] addr, input logic [1:0] typ,
                           input bit flush_first, input string tag);
        int n = is_if ? 4 : size_of(typ);
        int off = flush_first ? 1 : 0;
        int c = 0;
        bit seen = 1'b0;
        logic [31:0] exp = ref_read(addr, n);
        logic [31:0] got;
        if (is_if) begin
            bus.if_addr  = addr;
            bus.if_req   = 1'b1;
            bus.if_flush = flush_first;
        end else begin
            bus.mem_wr   = 1'b0;
            bus.mem_addr = addr;
            bus.mem_type = typ;
            bus.mem_req  = 1'b1;
        end
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 1) bus.if_flush = 1'b0;
            if (c > off && c <= n + off)
                check_eq({tag, "_addr"}, bus.ram_addr, addr + 32'(c - off - 1));
            seen = is_if ? bus.if_done : bus.mem_done;
        end
        check_eq({tag, "_done"}, 32'(seen), 32'd1);
        if (seen) begin
            check_eq({tag, "_lat"}, 32'(c), 32'(n + 2 + off));
            got = is_if ? bus.if_inst : bus.mem_load_data;
            check_eq({tag, "_data"}, got, exp);
        end
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(is_if ? bus.if_done : bus.mem_done), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [1:0] typ, input logic [31:0] data,
                            input int freeze_at, input string tag);
        int n = size_of(typ);
        int extra = (freeze_at > 0) ? 3 : 0;
        int c = 0;
        bit seen = 1'b0;
        logic [39:0] e;
        wlog.delete();
        bus.mem_wr         = 1'b1;
        bus.mem_addr       = addr;
        bus.mem_type       = typ;
        bus.mem_store_data = data;
        bus.mem_req        = 1'b1;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (freeze_at > 0) begin
                if (c > freeze_at && c < freeze_at + 3)
                    check_eq({tag, "_wr_frozen"}, 32'(bus.ram_wr), 32'd0);
                if (c == freeze_at)     rdy = 1'b0;
                if (c == freeze_at + 3) rdy = 1'b1;
            end
            seen = bus.mem_done;
        end
        rdy = 1'b1;
        check_eq({tag, "_done"}, 32'(seen), 32'd1);
        if (seen) check_eq({tag, "_lat"}, 32'(c), 32'(n + 1 + extra));
        check_eq({tag, "_nwr"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            e = wlog[i];
            check_eq({tag, "_waddr"}, e[39:8], addr + 32'(i));
            check_eq({tag, "_wdata"}, 32'(e[7:0]), 32'(data[8*i +: 8]));
        end
        for (int i = 0; i < n; i++) ref_mem[8'(addr + 32'(i))] = data[8*i +: 8];
        bus.mem_req = 1'b0;
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(bus.mem_done), 32'd0);
    endtask

    task automatic do_conflict();
        int c = 0;
        logic [39:0] e;
        logic [31:0] data = 32'hDEADBEEF;
        wlog.delete();
        bus.mem_wr = 1'b1; bus.mem_addr = 32'h200; bus.mem_type = 2'b10;
        bus.mem_store_data = data; bus.if_addr = 32'h200;
        bus.mem_req = 1'b1; bus.if_req = 1'b1;
        while (!bus.mem_done && !bus.if_done && c < 40) begin
            @(negedge clk);
            c++;
        end
        check_eq("cf_mem_first", 32'(bus.mem_done), 32'd1);
        check_eq("cf_if_quiet", 32'(bus.if_done), 32'd0);
        check_eq("cf_mem_lat", 32'(c), 32'd5);
        check_eq("cf_nwr", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            e = wlog[i];
            check_eq("cf_waddr", e[39:8], 32'h200 + 32'(i));
            check_eq("cf_wdata", 32'(e[7:0]), 32'(data[8*i +: 8]));
        end
        for (int i = 0; i < 4; i++) ref_mem[8'(32'h200 + 32'(i))] = data[8*i +: 8];
        bus.mem_req = 1'b0;
        while (!bus.if_done && c < 60) begin
            @(negedge clk);
            c++;
        end
        check_eq("cf_if_lat", 32'(c), 32'd12);
        check_eq("cf_if_inst", bus.if_inst, 32'hDEADBEEF);
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_flush();
        int p = n_if_pulses;
        logic [31:0] inst_before = bus.if_inst;
        bus.if_addr = 32'h300;
        bus.if_req  = 1'b1;
        for (int c = 1; c <= 3; c++) @(negedge clk);
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        @(negedge clk);
        bus.if_flush = 1'b0;
        do_read(1'b0, 32'h40, 2'b00, 1'b0, "flush_ld");
        check_eq("flush_no_done", 32'(n_if_pulses), 32'(p));
        check_eq("flush_inst_hold", bus.if_inst, inst_before);
    endtask

    task automatic do_async_reset();
        int p = n_mem_pulses;
        bus.mem_wr = 1'b0; bus.mem_addr = 32'h80; bus.mem_type = 2'b10;
        bus.mem_req = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_ram_addr", bus.ram_addr, 32'd0);
        check_eq("ar_ram_wr", 32'(bus.ram_wr), 32'd0);
        check_eq("ar_ram_dout", 32'(bus.ram_dout), 32'd0);
        check_eq("ar_mem_done", 32'(bus.mem_done), 32'd0);
        check_eq("ar_load_data", bus.mem_load_data, 32'd0);
        check_eq("ar_if_inst", bus.if_inst, 32'd0);
        check_eq("ar_if_done", 32'(bus.if_done), 32'd0);
        @(negedge clk);
        bus.mem_req = 1'b0;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("ar_no_done", 32'(n_mem_pulses), 32'(p));
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.mem_req = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0;
        bus.mem_type = 2'b00; bus.mem_store_data = '0;
`ifdef IO_BUFFER_FULL_EN
        bus.io_buffer_full = 1'b0;
`endif
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(negedge clk);
        check_eq("rst_ram_addr", bus.ram_addr, 32'd0);
        check_eq("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        check_eq("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
        check_eq("rst_if_done", 32'(bus.if_done), 32'd0);
        check_eq("rst_if_inst", bus.if_inst, 32'd0);
        check_eq("rst_mem_done", 32'(bus.mem_done), 32'd0);
        check_eq("rst_load_data", bus.mem_load_data, 32'd0);
        ram_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        do_write(32'h100, 2'b10, 32'h00000513, 0, "st_inst");
        do_read(1'b1, 32'h100, 2'b10, 1'b0, "fetch");
        check_eq("fetch_inst", bus.if_inst, 32'h00000513);
        do_conflict();
        do_write(32'h11, 2'b01, 32'h0000FF80, 0, "st_half");
        do_read(1'b0, 32'h11, 2'b01, 1'b0, "ld_half");
        check_eq("ld_half_val", bus.mem_load_data, 32'h0000FF80);
        do_flush();
        do_read(1'b1, 32'h500, 2'b10, 1'b1, "flush_idle");
        do_write(32'h600, 2'b10, 32'hA5C3_1E77, 2, "freeze");
        do_read(1'b0, 32'h600, 2'b10, 1'b0, "freeze_rb");
        do_read(1'b1, 32'hFFFF_FFFE, 2'b10, 1'b0, "wrap_if");
        do_write(32'hFFFF_FFFF, 2'b01, 32'h0000_3C4D, 0, "wrap_st");
        do_async_reset();

        for (int k = 0; k < 40; k++) begin
            int op = $urandom_range(0, 2);
            logic [31:0] addr = $urandom;
            logic [1:0] typ = 2'($urandom_range(0, 3));
            logic [31:0] data = $urandom;
            case (op)
                0:       do_read(1'b1, addr, 2'b10, ($urandom_range(0, 3) == 0), "rnd_if");
                1:       do_read(1'b0, addr, typ, 1'b0, "rnd_ld");
                default: do_write(addr, typ, data, 0, "rnd_st");
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
